// File: rtl/vgm_axi_write_slave.sv
// ============================================================================
// Module      : vgm_axi_write_slave
// Description : AXI write-channel slave. It queues AW requests, converts W
//               beats into a memory write port and returns OKAY/SLVERR on B.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vgm_axi_write_slave #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int AW_DEPTH   = 4,
    parameter int B_DEPTH    = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ID_WIDTH-1:0]   AWID,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [LEN_WIDTH-1:0]  AWLEN,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [ID_WIDTH-1:0]   WID,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_WIDTH-1:0]   BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    localparam int AW_PW = $clog2(AW_DEPTH);
    localparam int B_PW  = $clog2(B_DEPTH);
    localparam logic [AW_PW:0]          AW_FULL    = (AW_PW+1)'(AW_DEPTH);
    localparam logic [B_PW:0]           B_FULL     = (B_PW+1)'(B_DEPTH);
    localparam logic [ADDR_WIDTH-1:0]   BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [1:0]              RESP_OKAY  = 2'b00;
    localparam logic [1:0]              RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t state;

    // AW FIFO
    logic [ID_WIDTH-1:0]   aw_id_mem   [AW_DEPTH];
    logic [ADDR_WIDTH-1:0] aw_addr_mem [AW_DEPTH];
    logic [LEN_WIDTH-1:0]  aw_len_mem  [AW_DEPTH];
    logic [AW_PW-1:0]      aw_wp, aw_rp;
    logic [AW_PW:0]        aw_cnt;
    logic                  aw_full, aw_empty, aw_push, aw_pop;

    // B FIFO
    logic [ID_WIDTH-1:0]   b_id_mem   [B_DEPTH];
    logic [1:0]            b_resp_mem [B_DEPTH];
    logic [B_PW-1:0]       b_wp, b_rp;
    logic [B_PW:0]         b_cnt;
    logic                  b_full, b_empty, b_push, b_pop;

    // Active burst
    logic [ID_WIDTH-1:0]   cur_id;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  cur_len;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic                  err;

    logic                  w_hs, id_ok, w_end, err_next;
    logic [1:0]            resp_in;

    assign aw_full  = (aw_cnt == AW_FULL);
    assign aw_empty = (aw_cnt == '0);
    assign AWREADY  = !aw_full && !ARESET;
    assign aw_push  = AWVALID && AWREADY;
    assign aw_pop   = (state == IDLE) && !aw_empty && !b_full;

    assign b_full   = (b_cnt == B_FULL);
    assign b_empty  = (b_cnt == '0);
    assign BVALID   = !b_empty;
    assign BID      = b_empty ? '0 : b_id_mem[b_rp];
    assign BRESP    = b_empty ? '0 : b_resp_mem[b_rp];
    assign b_pop    = BVALID && BREADY;

    assign WREADY   = (state == DATA);
    assign w_hs     = WVALID && WREADY;
    assign id_ok    = (WID == cur_id);
    // A burst closes on WLAST or on its final beat, whichever comes first.
    assign w_end    = WLAST || (beat_cnt == cur_len);
    assign err_next = err || !id_ok || (WLAST != (beat_cnt == cur_len));
    assign resp_in  = err_next ? RESP_SLVERR : RESP_OKAY;
    assign b_push   = w_hs && w_end;

    always_ff @(posedge ACLK) begin
        if (aw_push) begin
            aw_id_mem[aw_wp]   <= AWID;
            aw_addr_mem[aw_wp] <= AWADDR;
            aw_len_mem[aw_wp]  <= AWLEN;
        end
        if (b_push) begin
            b_id_mem[b_wp]   <= cur_id;
            b_resp_mem[b_wp] <= resp_in;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_wp  <= '0;
            aw_rp  <= '0;
            aw_cnt <= '0;
            b_wp   <= '0;
            b_rp   <= '0;
            b_cnt  <= '0;
        end else begin
            if (aw_push) aw_wp <= aw_wp + 1'b1;
            if (aw_pop)  aw_rp <= aw_rp + 1'b1;
            case ({aw_push, aw_pop})
                2'b10:   aw_cnt <= aw_cnt + 1'b1;
                2'b01:   aw_cnt <= aw_cnt - 1'b1;
                default: aw_cnt <= aw_cnt;
            endcase
            if (b_push) b_wp <= b_wp + 1'b1;
            if (b_pop)  b_rp <= b_rp + 1'b1;
            case ({b_push, b_pop})
                2'b10:   b_cnt <= b_cnt + 1'b1;
                2'b01:   b_cnt <= b_cnt - 1'b1;
                default: b_cnt <= b_cnt;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            cur_id    <= '0;
            cur_addr  <= '0;
            cur_len   <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (aw_pop) begin
                        cur_id   <= aw_id_mem[aw_rp];
                        cur_addr <= aw_addr_mem[aw_rp];
                        cur_len  <= aw_len_mem[aw_rp];
                        beat_cnt <= '0;
                        err      <= 1'b0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        // Beats with a foreign WID are dropped and do not advance the address.
                        if (id_ok) begin
                            mem_wen   <= 1'b1;
                            mem_addr  <= cur_addr;
                            mem_wdata <= WDATA;
                            cur_addr  <= cur_addr + BEAT_BYTES;
                        end
                        err <= err_next;
                        if (w_end) state    <= IDLE;
                        else       beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vgm_axi_write_slave.sv
// ============================================================================
// Module      : tb_vgm_axi_write_slave
// Description : Directed self-checking bench for vgm_axi_write_slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vgm_axi_write_slave;

    logic        ACLK;
    logic        ARESET;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic        AWVALID;
    logic        AWREADY;
    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    vgm_axi_write_slave dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .AWID      (AWID),
        .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WID       (WID),
        .WDATA     (WDATA),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BID       (BID),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  bid_q[$];
    logic [1:0]  bresp_q[$];

    always @(negedge ACLK) begin
        if (mem_wen === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (BVALID === 1'b1 && BREADY === 1'b1) begin
            bid_q.push_back(BID);
            bresp_q.push_back(BRESP);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_q();
        wa_q.delete();
        wd_q.delete();
        bid_q.delete();
        bresp_q.delete();
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        logic hs;
        int   n;
        AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
        n = 0;
        do begin
            hs = AWREADY;
            tick();
            n++;
        end while (!hs && n < 100);
        AWVALID = 1'b0;
        check("aw_handshake", hs, 1);
    endtask

    task automatic send_w(input logic [3:0] id, input logic [31:0] data, input logic last);
        logic hs;
        int   n;
        WID = id; WDATA = data; WLAST = last; WVALID = 1'b1;
        n = 0;
        do begin
            hs = WREADY;
            tick();
            n++;
        end while (!hs && n < 100);
        WVALID = 1'b0;
        WLAST  = 1'b0;
        check("w_handshake", hs, 1);
    endtask

    task automatic wait_b(input int n);
        int c;
        c = 0;
        while (bid_q.size() < n && c < 200) begin
            tick();
            c++;
        end
        check("b_count", bid_q.size(), n);
    endtask

    initial begin
        int   accepted;
        logic hs;

        ARESET = 1'b1; AWID = '0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;

        // Reset values
        repeat (3) tick();
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_bid", BID, 0);
        check("rst_bresp", BRESP, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        ARESET = 1'b0;
        tick();
        check("post_rst_awready", AWREADY, 1);

        // Single 4-beat burst with 2-cycle AW-to-WREADY latency
        clear_q();
        send_aw(4'd3, 32'h100, 4'd3);
        check("aw2w_lat_n1", WREADY, 0);
        tick();
        check("aw2w_lat_n2", WREADY, 1);
        send_w(4'd3, 32'hD000_0000, 1'b0);
        send_w(4'd3, 32'hD000_0001, 1'b0);
        send_w(4'd3, 32'hD000_0002, 1'b0);
        send_w(4'd3, 32'hD000_0003, 1'b1);
        check("single_bvalid", BVALID, 1);
        check("single_wready_gap", WREADY, 0);
        wait_b(1);
        check("single_nwrites", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("single_addr", wa_q[i], 32'h100 + 32'(4 * i));
            check("single_data", wd_q[i], 32'hD000_0000 + 32'(i));
        end
        check("single_bid", bid_q[0], 3);
        check("single_bresp", bresp_q[0], 2'b00);

        // Outstanding limit: one in the burst registers plus four queued
        clear_q();
        accepted = 0;
        AWLEN = 4'd0; AWVALID = 1'b1;
        for (int c = 0; c < 12; c++) begin
            AWID   = 4'(accepted + 1);
            AWADDR = 32'h1000 + 32'(accepted * 16);
            hs = AWREADY;
            tick();
            if (hs) accepted++;
        end
        AWVALID = 1'b0;
        check("ost_accepted", accepted, 5);
        check("ost_awready_low", AWREADY, 0);
        send_w(4'd1, 32'hA1, 1'b1);
        send_aw(4'd6, 32'h1050, 4'd0);
        for (int k = 2; k <= 6; k++)
            send_w(4'(k), 32'hA0 + 32'(k), 1'b1);
        wait_b(6);
        check("ost_nwrites", wa_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check("ost_bid_order", bid_q[k], 64'(k + 1));
            check("ost_bresp", bresp_q[k], 2'b00);
            check("ost_addr", wa_q[k], 32'h1000 + 32'(k * 16));
        end

        // Early WLAST
        clear_q();
        send_aw(4'd7, 32'h200, 4'd3);
        send_w(4'd7, 32'hE0, 1'b0);
        send_w(4'd7, 32'hE1, 1'b1);
        wait_b(1);
        check("early_nwrites", wa_q.size(), 2);
        check("early_addr1", wa_q[1], 32'h204);
        check("early_bid", bid_q[0], 7);
        check("early_bresp", bresp_q[0], 2'b10);

        // Missing WLAST
        clear_q();
        send_aw(4'd8, 32'h300, 4'd1);
        send_w(4'd8, 32'hF0, 1'b0);
        send_w(4'd8, 32'hF1, 1'b0);
        wait_b(1);
        check("miss_nwrites", wa_q.size(), 2);
        check("miss_bid", bid_q[0], 8);
        check("miss_bresp", bresp_q[0], 2'b10);

        // WID mismatch on beat 0: beat dropped, address not advanced
        clear_q();
        send_aw(4'd5, 32'h400, 4'd3);
        send_w(4'd6, 32'hC0, 1'b0);
        send_w(4'd5, 32'hC1, 1'b0);
        send_w(4'd5, 32'hC2, 1'b0);
        send_w(4'd5, 32'hC3, 1'b1);
        wait_b(1);
        check("wid_nwrites", wa_q.size(), 3);
        check("wid_data0", wd_q[0], 32'hC1);
        check("wid_addr0", wa_q[0], 32'h400);
        check("wid_data2", wd_q[2], 32'hC3);
        check("wid_addr2", wa_q[2], 32'h408);
        check("wid_bid", bid_q[0], 5);
        check("wid_bresp", bresp_q[0], 2'b10);

        // B backpressure: four responses fill the B FIFO, fifth burst stalls
        clear_q();
        BREADY = 1'b0;
        for (int k = 0; k < 5; k++)
            send_aw(4'(9 + k), 32'h2000 + 32'(4 * k), 4'd0);
        for (int k = 0; k < 4; k++)
            send_w(4'(9 + k), 32'hB0 + 32'(k), 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("bp_wready_low", WREADY, 0);
        end
        check("bp_bvalid", BVALID, 1);
        check("bp_bid_head", BID, 9);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        send_w(4'd13, 32'hB4, 1'b1);
        BREADY = 1'b1;
        wait_b(5);
        for (int k = 0; k < 5; k++)
            check("bp_bid_order", bid_q[k], 64'(9 + k));
        check("bp_nwrites", wa_q.size(), 5);

        // Address wrap
        clear_q();
        send_aw(4'd2, 32'hFFFF_FFFC, 4'd1);
        send_w(4'd2, 32'h11, 1'b0);
        send_w(4'd2, 32'h22, 1'b1);
        wait_b(1);
        check("wrap_addr0", wa_q[0], 32'hFFFF_FFFC);
        check("wrap_addr1", wa_q[1], 32'h0000_0000);
        check("wrap_bresp", bresp_q[0], 2'b00);

        // Reset mid-burst with a pending response
        BREADY = 1'b0;
        send_aw(4'd1, 32'h700, 4'd0);
        send_w(4'd1, 32'h77, 1'b1);
        send_aw(4'd4, 32'h500, 4'd3);
        send_w(4'd4, 32'h50, 1'b0);
        send_w(4'd4, 32'h51, 1'b0);
        check("mid_pre_bvalid", BVALID, 1);
        check("mid_pre_mem_wen", mem_wen, 1);
        ARESET = 1'b1;
        tick();
        check("mid_rst_bvalid", BVALID, 0);
        check("mid_rst_wready", WREADY, 0);
        check("mid_rst_mem_wen", mem_wen, 0);
        check("mid_rst_awready", AWREADY, 0);
        ARESET = 1'b0;
        BREADY = 1'b1;
        clear_q();
        repeat (10) tick();
        check("mid_no_b", bid_q.size(), 0);
        check("mid_no_writes", wa_q.size(), 0);
        send_aw(4'd4, 32'h600, 4'd0);
        send_w(4'd4, 32'h66, 1'b1);
        wait_b(1);
        check("fresh_bid", bid_q[0], 4);
        check("fresh_bresp", bresp_q[0], 2'b00);
        check("fresh_addr", wa_q[0], 32'h600);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
